data_bus_arbiter: RTL
=====================

# data_bus_arbiter

- Parametrised, registered successor to the LC-3 datapath bus multiplexer.
- Accepts N gated sources, each a W-bit value plus a gate-enable bit, and drives one registered bus value.
- Adds, over the combinational one-hot mux:
  - selectable conflict resolution (zero, fixed priority, round-robin);
  - optional hold-last-value when no gate is asserted;
  - conflict flag, sticky flag and saturating conflict counter for debug.
- Sits between the datapath gate sources (PC, MDR, ALU, MARMUX and any added sources) and every bus consumer (MAR, MDR, IR, register file, PC mux).

## Interface

Parameters:
- N, default 4: number of sources. Legal range 2..16.
- W, default 16: data width.
- MODE, default 0: conflict policy. 0 = drive zero, 1 = fixed priority (lowest index wins), 2 = round-robin.
- HOLD_LAST, default 0: 0 = bus goes to 0 when idle; 1 = bus holds the last granted value.
- CNT_W, default 8: conflict counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Gate_sig  in  N  gate enables; bit i enables source i.
- Gate_data  in  N*W  packed source data; source i occupies bits [i*W +: W].
- Clr_stats  in  1  synchronous clear of Conflict_sticky and Conflict_count.
- Bus_out  out  W  registered bus value.
- Bus_valid  out  1  a source was granted in the previous cycle.
- Bus_src  out  max(1,$clog2(N))  index of the granted source; 0 when Bus_valid=0.
- Conflict  out  1  previous cycle had more than one gate asserted (single-cycle pulse).
- Conflict_sticky  out  1  set by any conflict; cleared only by reset or Clr_stats.
- Conflict_count  out  CNT_W  saturating count of conflict cycles.

## Operation

- Each cycle, the arbiter evaluates Gate_sig combinationally. Results are registered on the rising edge of Clk.
- Zero gates asserted:
  - Bus_valid <= 0 and Bus_src <= 0.
  - Bus_out <= 0 when HOLD_LAST=0; Bus_out is unchanged when HOLD_LAST=1.
- Exactly one gate (bit i) asserted: grant i. Bus_out <= source i data, Bus_valid <= 1, Bus_src <= i. This applies in every MODE.
- Two or more gates asserted: Conflict <= 1, Conflict_sticky <= 1, and Conflict_count increments, saturating at 2^CNT_W-1.
  - MODE 0: no grant. Bus_out <= 0 (regardless of HOLD_LAST), Bus_valid <= 0, Bus_src <= 0.
  - MODE 1: grant the lowest asserted index.
  - MODE 2: grant the first asserted index at or after rr_ptr, wrapping from N-1 to 0.
- Round-robin pointer rr_ptr (MODE 2 only):
  - Reset value 0.
  - On any grant to index g, rr_ptr <= (g+1) mod N. When g = N-1, rr_ptr wraps to 0.
  - Unchanged on idle cycles.
- Clr_stats:
  - Clears Conflict_sticky and Conflict_count.
  - If a conflict occurs in the same cycle, clear wins for Conflict_count (result 0). Conflict_sticky still ends at 1. The Conflict pulse is unaffected.
- Reset values (Reset_n=0 at an edge): Bus_out=0, Bus_valid=0, Bus_src=0, Conflict=0, Conflict_sticky=0, Conflict_count=0, rr_ptr=0.
- Reset overrides all inputs, including a reset asserted mid-conflict.
- Gate_data of ungated sources is ignored. X on an ungated source must not propagate to Bus_out.

## Timing

- Latency: exactly 1 cycle from Gate_sig/Gate_data sampled at edge k to Bus_out/Bus_valid/Bus_src/Conflict valid after edge k.
- The FSM consumer samples the bus one cycle after asserting a gate.
- No back-pressure; a new selection is accepted every cycle.
- Conflict is high for exactly one cycle per conflicting input cycle. Back-to-back conflicts hold it high continuously.
- The first edge with Reset_n=1 after reset evaluates inputs normally.

## Test plan

- Reset, then single gates: Gate_sig=4'b0100 with data2=16'hBEEF -> next cycle Bus_out=BEEF, Bus_valid=1, Bus_src=2, Conflict=0.
- Idle with HOLD_LAST=1 after the BEEF grant: Gate_sig=0 for 3 cycles -> Bus_out stays BEEF and Bus_valid=0. Repeat with HOLD_LAST=0 -> Bus_out=0.
- MODE 0 conflict: Gate_sig=4'b0011 -> Bus_out=0, Bus_valid=0, Conflict=1 for one cycle, Conflict_sticky=1, Conflict_count=1.
- MODE 1 conflict: Gate_sig=4'b1010 with data1=1111, data3=3333 -> Bus_out=1111, Bus_src=1.
- MODE 2 round-robin: Gate_sig=4'b1111 held 5 cycles from reset -> Bus_src sequence 0,1,2,3,0, wrapping. Conflict_count=5.
- Saturation and clear with CNT_W=2: 5 conflict cycles -> count 3 (saturated). Then assert Clr_stats concurrently with a conflict -> count 0, sticky 1. Then pull Reset_n low mid-conflict -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_bus_arbiter
//  Purpose  : Registered N-source gated bus mux with conflict resolution
//             (zero / fixed priority / round-robin) and conflict statistics.
//  Revision : 1.0  initial release
// ============================================================================
module data_bus_arbiter #(
    parameter int N         = 4,
    parameter int W         = 16,
    parameter int MODE      = 0,
    parameter int HOLD_LAST = 0,
    parameter int CNT_W     = 8
) (
    input  logic                                          Clk,
    input  logic                                          Reset_n,
    input  logic [N-1:0]                                  Gate_sig,
    input  logic [N*W-1:0]                                Gate_data,
    input  logic                                          Clr_stats,
    output logic [W-1:0]                                  Bus_out,
    output logic                                          Bus_valid,
    output logic [(($clog2(N) > 1) ? $clog2(N) : 1)-1:0]  Bus_src,
    output logic                                          Conflict,
    output logic                                          Conflict_sticky,
    output logic [CNT_W-1:0]                              Conflict_count
);

    localparam int               c_SRC_W   = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [W-1:0]       r_bus;
    logic               r_valid;
    logic [c_SRC_W-1:0] r_src;
    logic               r_conflict;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_count;
    logic [c_SRC_W-1:0] r_rr_ptr;

    logic               w_any;
    logic               w_multi;
    logic [c_SRC_W-1:0] w_low_idx;
    logic [c_SRC_W-1:0] w_rr_hi_idx;
    logic               w_rr_hi_found;
    logic [c_SRC_W-1:0] w_grant_idx;
    logic               w_grant;
    logic [W-1:0]       w_sel_data;
    logic [W-1:0]       w_bus_nxt;
    logic [c_SRC_W-1:0] w_rr_nxt;

    assign w_any   = |Gate_sig;
    assign w_multi = |(Gate_sig & (Gate_sig - N'(1)));

    // Descending scan so the lowest asserted index is the one left standing.
    always_comb begin
        w_low_idx     = '0;
        w_rr_hi_idx   = '0;
        w_rr_hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (Gate_sig[i]) begin
                w_low_idx = c_SRC_W'(i);
            end
            if (Gate_sig[i] && (i >= int'(r_rr_ptr))) begin
                w_rr_hi_idx   = c_SRC_W'(i);
                w_rr_hi_found = 1'b1;
            end
        end
    end

    // Round-robin: first request at/after the pointer, else wrap to the lowest.
    always_comb begin
        w_grant_idx = w_low_idx;
        if (MODE == 2) begin
            w_grant_idx = w_rr_hi_found ? w_rr_hi_idx : w_low_idx;
        end
        w_grant = w_any && !(w_multi && (MODE == 0));
    end

    // Only the granted (hence gated) slice can reach the bus.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (c_SRC_W'(i) == w_grant_idx) begin
                w_sel_data = Gate_data[i*W +: W];
            end
        end
    end

    always_comb begin
        if (w_grant) begin
            w_bus_nxt = w_sel_data;
        end else if (!w_multi && (HOLD_LAST != 0)) begin
            w_bus_nxt = r_bus;
        end else begin
            w_bus_nxt = '0;
        end
        w_rr_nxt = (w_grant_idx == c_SRC_W'(N - 1)) ? '0 : w_grant_idx + c_SRC_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_bus      <= '0;
            r_valid    <= 1'b0;
            r_src      <= '0;
            r_conflict <= 1'b0;
            r_sticky   <= 1'b0;
            r_count    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_bus      <= w_bus_nxt;
            r_valid    <= w_grant;
            r_src      <= w_grant ? w_grant_idx : '0;
            r_conflict <= w_multi;
            if (w_grant) begin
                r_rr_ptr <= w_rr_nxt;
            end
            // A same-cycle conflict keeps sticky set; clear wins on the count.
            if (w_multi) begin
                r_sticky <= 1'b1;
            end else if (Clr_stats) begin
                r_sticky <= 1'b0;
            end
            if (Clr_stats) begin
                r_count <= '0;
            end else if (w_multi && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign Bus_out         = r_bus;
    assign Bus_valid       = r_valid;
    assign Bus_src         = r_src;
    assign Conflict        = r_conflict;
    assign Conflict_sticky = r_sticky;
    assign Conflict_count  = r_count;

endmodule
`default_nettype wire
